// File: rtl/pulse_stretcher_pkg.sv
// rtl/pulse_stretcher_pkg.sv - shared button package: stretcher states, queue width, shaper constants
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ASSERT = 2'b01,
        ST_GAP    = 2'b10
    } ps_state_e;

    localparam int PEND_W = 4;

    localparam int SHAPER_SYNC_STAGES     = 2;
    localparam int SHAPER_DEBOUNCE_CYCLES = 4;

    // Width that holds max(a, b) without wrapping.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pulse_stretcher_down_counter.sv
// rtl/pulse_stretcher_down_counter.sv - loadable down counter that stops at zero
module pulse_stretcher_down_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over decrement; the count saturates at zero instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = loadVal;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - turns trig requests into queued active-low button presses
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int HOLD_CYCLES = 50,
    parameter int GAP_CYCLES  = 10,
    parameter int PEND_MAX    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trig,
    output logic              btnOut,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              dropped
);

    localparam int                CW        = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam logic [CW-1:0]     HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]     GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_LIM  = PEND_W'(PEND_MAX);
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

    ps_state_e         state_q, state_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              btn_out_q, btn_out_d;
    logic              busy_q, busy_d;
    logic              dropped_q, dropped_d;

    logic              load;
    logic [CW-1:0]     load_val;
    logic              cnt_en;
    logic              cnt_zero;
    logic              room;

    pulse_stretcher_down_counter #(.W(CW)) u_counter (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .loadVal (load_val),
        .en      (cnt_en),
        .zero    (cnt_zero)
    );

    assign room = (pending_q < PEND_LIM);

    // Counter holds (remaining cycles - 1); zero marks the last cycle of a phase.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        dropped_d = 1'b0;
        load      = 1'b0;
        load_val  = HOLD_LOAD;
        cnt_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d = ST_ASSERT;
                    load    = 1'b1;
                end
            end
            ST_ASSERT: begin
                cnt_en = 1'b1;
                if (trig) begin
                    if (room) pending_d = pending_q + PEND_ONE;
                    else      dropped_d = 1'b1;
                end
                if (cnt_zero) begin
                    state_d  = ST_GAP;
                    load     = 1'b1;
                    load_val = GAP_LOAD;
                end
            end
            ST_GAP: begin
                cnt_en = 1'b1;
                if (!cnt_zero) begin
                    if (trig) begin
                        if (room) pending_d = pending_q + PEND_ONE;
                        else      dropped_d = 1'b1;
                    end
                end else if (pending_q != '0) begin
                    // A trig here refills the slot being consumed, so the count holds.
                    state_d = ST_ASSERT;
                    load    = 1'b1;
                    if (!trig) pending_d = pending_q - PEND_ONE;
                end else if (trig) begin
                    state_d = ST_ASSERT;
                    load    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        btn_out_d = (state_d != ST_ASSERT);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            btn_out_q <= 1'b1;
            busy_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            btn_out_q <= btn_out_d;
            busy_q    <= busy_d;
            dropped_q <= dropped_d;
        end
    end

    assign btnOut  = btn_out_q;
    assign busy    = busy_q;
    assign pending = pending_q;
    assign dropped = dropped_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - randomized and directed self-checking bench for pulse_stretcher
module tb_pulse_stretcher;

    localparam int H  = 4;
    localparam int G  = 2;
    localparam int PM = 2;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       trig  = 1'b0;
    logic       btnOut;
    logic       busy;
    logic [3:0] pending;
    logic       dropped;

    always #5 clk = ~clk;

    pulse_stretcher #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .PEND_MAX(PM)) dut (
        .clk     (clk),
        .reset   (reset),
        .trig    (trig),
        .btnOut  (btnOut),
        .busy    (busy),
        .pending (pending),
        .dropped (dropped)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit check_en = 1'b0;

    // Model: each accepted request owns a press window starting at a known cycle.
    int starts[$];
    int trigs[$];
    int last_start = -1000;
    int last_drop  = -1000;
    int prev_drop  = -1000;

    // Loopback receiver: falling-edge detector on btnSense.
    logic sense_q  = 1'b1;
    logic sense_qq = 1'b1;
    int   rx_cnt   = 0;
    always @(posedge clk) begin
        sense_q  <= btnOut;
        sense_qq <= sense_q;
        if (sense_qq && !sense_q) rx_cnt <= rx_cnt + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        starts.delete();
        trigs.delete();
        last_start = -1000;
        last_drop  = -1000;
        prev_drop  = -1000;
    endtask

    // A request fits if fewer than PM requests are still waiting after this cycle.
    task automatic model_trig(input int c);
        int waiting;
        int s;
        waiting = 0;
        foreach (starts[i]) if (starts[i] > c + 1) waiting++;
        if (waiting < PM) begin
            s = (c + 1 > last_start + H + G) ? c + 1 : last_start + H + G;
            starts.push_back(s);
            trigs.push_back(c);
            last_start = s;
        end else begin
            prev_drop = last_drop;
            last_drop = c;
        end
        while (starts.size() > 0 && starts[0] + H + G < c - 2) begin
            void'(starts.pop_front());
            void'(trigs.pop_front());
        end
    endtask

    always @(negedge clk) begin
        int eb, ebusy, ep, ed;
        if (check_en) begin
            eb = 1; ebusy = 0; ep = 0;
            foreach (starts[i]) begin
                if (starts[i] <= cyc && cyc <= starts[i] + H - 1)     eb = 0;
                if (starts[i] <= cyc && cyc <= starts[i] + H + G - 1) ebusy = 1;
                if (trigs[i] < cyc && starts[i] > cyc)                ep++;
            end
            ed = (last_drop == cyc - 1 || prev_drop == cyc - 1) ? 1 : 0;
            chk("btnOut",  int'(btnOut),  eb);
            chk("busy",    int'(busy),    ebusy);
            chk("pending", int'(pending), ep);
            chk("dropped", int'(dropped), ed);
        end
    end

    task automatic step(input bit t);
        @(posedge clk);
        #1;
        cyc++;
        trig = t;
        if (t) model_trig(cyc);
    endtask

    task automatic do_reset();
        check_en = 1'b0;
        trig     = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_btnOut",  int'(btnOut),  1);
        chk("rst_busy",    int'(busy),    0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_dropped", int'(dropped), 0);
        @(posedge clk);
        #2 reset = 1'b0;
        model_clear();
        check_en = 1'b1;
    endtask

    task automatic run_pattern(input bit [31:0] pat, input int n,
                               output bit [31:0] btr, output bit [31:0] bsy,
                               output int presses, output int maxp, output int drops,
                               output int drop_at, output int bad_len);
        int run;
        run = 0; btr = '0; bsy = '0; presses = 0; maxp = 0; drops = 0;
        drop_at = -1; bad_len = 0;
        for (int i = 0; i < n; i++) begin
            step(pat[i]);
            btr[i] = btnOut;
            bsy[i] = busy;
            if (int'(pending) > maxp) maxp = int'(pending);
            if (dropped) begin
                drops++;
                drop_at = i;
            end
            if (!btnOut) run++;
            else begin
                if (run > 0) begin
                    presses++;
                    if (run != H) bad_len++;
                end
                run = 0;
            end
        end
    endtask

    initial begin
        bit [31:0] btr, bsy;
        int presses, maxp, drops, drop_at, bad_len, rx0, prob;

        do_reset();

        // Single press, trig in the first cycle after reset release.
        run_pattern(32'h1, 10, btr, bsy, presses, maxp, drops, drop_at, bad_len);
        chk("single_trace", int'(btr), int'(32'b1111100001));
        chk("single_busy",  int'(bsy), int'(32'b0001111110));

        // Queueing three requests, also fed through the loopback receiver.
        rx0 = rx_cnt;
        run_pattern(32'h7, 22, btr, bsy, presses, maxp, drops, drop_at, bad_len);
        chk("queue_trace",   int'(btr), int'(32'b1111100001100001100001));
        chk("queue_presses", presses, 3);
        chk("queue_maxpend", maxp, 2);
        chk("queue_drops",   drops, 0);
        chk("queue_badlen",  bad_len, 0);
        chk("loopback_rx",   rx_cnt - rx0, 3);

        // Overflow: fourth request is discarded.
        run_pattern(32'hF, 22, btr, bsy, presses, maxp, drops, drop_at, bad_len);
        chk("ovf_trace",   int'(btr), int'(32'b1111100001100001100001));
        chk("ovf_presses", presses, 3);
        chk("ovf_maxpend", maxp, 2);
        chk("ovf_drops",   drops, 1);
        chk("ovf_drop_at", drop_at, 4);

        // Back-to-back: trig on the last gap cycle with nothing queued.
        run_pattern(32'h41, 14, btr, bsy, presses, maxp, drops, drop_at, bad_len);
        chk("b2b_trace", int'(btr), int'(32'b11100001100001));
        chk("b2b_busy",  int'(bsy), int'(32'b01111111111110));

        // Reset during the second low cycle with one request queued.
        step(1'b1);
        step(1'b1);
        step(1'b0);
        chk("mid_btnOut",  int'(btnOut),  0);
        chk("mid_pending", int'(pending), 1);
        do_reset();
        run_pattern(32'h0, 20, btr, bsy, presses, maxp, drops, drop_at, bad_len);
        chk("post_rst_trace",   int'(btr), int'(32'hFFFFF));
        chk("post_rst_presses", presses, 0);

        // Randomized traffic with varying request density.
        for (int seg = 0; seg < 20; seg++) begin
            prob = int'($urandom_range(5, 80));
            for (int k = 0; k < 200; k++) begin
                step(int'($urandom_range(0, 99)) < prob);
                if ($urandom_range(0, 999) == 0) do_reset();
            end
        end
        for (int k = 0; k < 30; k++) step(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 The module SHALL have parameter HOLD_CYCLES, default 50: the number of cycles btnOut is held low per press; legal values are 1 or more.
REQ-002 The module SHALL have parameter GAP_CYCLES, default 10: the number of cycles btnOut is held high between consecutive presses; legal values are 1 or more.
REQ-003 The module SHALL have parameter PEND_MAX, default 3: the maximum number of queued requests; legal values are 1 to 15.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port trig, input, 1 bit: a press request, sampled on every rising edge of clk; each high cycle is one request.
REQ-007 The module SHALL have port btnOut, output, 1 bit: an active-low press waveform with the same polarity as a pushbutton; it idles high.
REQ-008 The module SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 The module SHALL have port pending, output, 4 bits: the number of queued requests.
REQ-010 The module SHALL have port dropped, output, 1 bit: a one-cycle pulse when a request is discarded.

Function
REQ-011 The module SHALL implement an FSM with states IDLE, ASSERT and GAP; all outputs SHALL be registered.
REQ-012 In IDLE, trig=1 SHALL cause a move to ASSERT; btnOut SHALL go low on the first cycle after the trig cycle (latency 1).
REQ-013 In ASSERT, btnOut SHALL be 0 for exactly HOLD_CYCLES cycles, after which the FSM SHALL move to GAP.
REQ-014 In GAP, btnOut SHALL be 1 for exactly GAP_CYCLES cycles.
REQ-015 On the last GAP cycle, if pending>0, the FSM SHALL decrement pending and enter ASSERT; otherwise it SHALL enter IDLE.
REQ-016 trig=1 in ASSERT or GAP SHALL increment pending if pending<PEND_MAX.
REQ-017 If pending==PEND_MAX, a trig SHALL instead assert dropped for one cycle (the cycle after trig), and pending SHALL be unchanged.
REQ-018 trig=1 on the last GAP cycle with pending==0 SHALL send the FSM straight to ASSERT without queueing.
REQ-019 trig=1 on the last GAP cycle with 0<pending≤PEND_MAX SHALL cause an increment and a decrement that cancel, leaving pending unchanged and dropping nothing.
REQ-020 trig=1 for N consecutive cycles SHALL be treated as N requests.
REQ-021 btnOut SHALL never be low for more or fewer than HOLD_CYCLES cycles per press.
REQ-022 The cycle counter SHALL be sized to ceil(log2(max(HOLD_CYCLES, GAP_CYCLES)+1)) bits and SHALL never wrap.
REQ-023 Any undefined state SHALL recover to IDLE on the next clock, with btnOut=1.

Reset
REQ-024 reset=1 SHALL immediately force the FSM to IDLE, btnOut=1, busy=0, pending=0, dropped=0 and the counter to 0, independent of clk.
REQ-025 Reset asserted mid-ASSERT SHALL release btnOut high at once; queued requests SHALL be discarded.
REQ-026 A trig in the first clock after reset deassertion SHALL be accepted normally.

Structure
REQ-027 The state encodings (IDLE=2'b00, ASSERT=2'b01, GAP=2'b10) and the pending width constant SHALL live in the shared button package, alongside the button shaper constants.
REQ-028 The hold/gap timing SHALL be a down_counter sub-module with inputs load, loadVal and en and output zero; the rest of the logic stays in pulse_stretcher.
REQ-029 pulse_stretcher SHALL be usable as a stimulus source for buttonShaper-style receivers, with btnOut wired directly to their btnSense input.

Verification (HOLD_CYCLES=4, GAP_CYCLES=2, PEND_MAX=2)
REQ-030 Single press: one trig pulse in IDLE -> btnOut low in cycles 1-4 after trig, high in cycles 5-6, busy=0 from cycle 7.
REQ-031 Queueing: 3 trig pulses in cycles 0, 1 and 2 -> 3 low windows of 4 cycles each separated by 2 high cycles; pending peaks at 2; dropped never asserts.
REQ-032 Overflow: 4 trig pulses in cycles 0-3 -> pending=2 and a dropped pulse in cycle 4; exactly 3 presses are produced.
REQ-033 Back-to-back: trig on the last GAP cycle with pending=0 -> btnOut low on the next cycle with no IDLE cycle in between.
REQ-034 Reset mid-hold: reset asserted in the 2nd low cycle with pending=1 -> btnOut=1 and pending=0 immediately; no further presses after reset release.
REQ-035 Loopback: btnOut drives a button shaper's btnSense; 3 requests -> exactly 3 single-cycle receiver pulses.
